bcd2bin: RTL and testbench



---
 rtl/bcd2bin_if.sv | 16 +
 rtl/bcd2bin.sv | 116 +++++++++++
 tb/tb_bcd2bin.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_if.sv
// bcd2bin_if: handshake/data bundle for the bcd2bin converter.
//   en      - start request (master -> slave)
//   bcd_in  - 4-digit packed BCD operand (master -> slave)
//   bin_out - 12-bit binary result (slave -> master)
//   ready   - one-cycle completion pulse (slave -> master)
//   err     - invalid digit or overflow flag, valid with ready (slave -> master)
interface bcd2bin_if;
    logic        en;
    logic [15:0] bcd_in;
    logic [11:0] bin_out;
    logic        ready;
    logic        err;

    modport master (output en, bcd_in, input bin_out, ready, err);
    modport slave  (input en, bcd_in, output bin_out, ready, err);
endinterface

// File: rtl/bcd2bin.sv
// bcd2bin: sequential 4-digit BCD to 12-bit binary converter using a
// 16-step reverse double-dabble (shift right, then subtract 3 from any
// BCD digit >= 8).
//   clk  - system clock, rising edge
//   RSTN - synchronous active-low reset
//   bus  - bcd2bin_if.slave: en/bcd_in in; bin_out/ready/err out
// A conversion loaded at edge k completes at edge k+16 (ready high for one
// cycle), then returns to IDLE at k+17; next load is possible at k+18.
module bcd2bin (
    input  logic        clk,
    input  logic        RSTN,
    bcd2bin_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        bad_q, bad_d;
    logic [11:0] bin_out_q, bin_out_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;

    // Any nibble above 9 makes the operand invalid.
    function automatic logic has_bad_digit(input logic [15:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    // Undo the BCD weighting after a right shift: a digit that received a
    // '1' from its upper neighbour became >= 8, but that bit is worth 5 in
    // decimal, so take 3 away. Digits >= 8 never underflow.
    function automatic logic [15:0] dabble_fix(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (r[4*i+3]) r[4*i +: 4] = r[4*i +: 4] - 4'd3;
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        bad_d     = bad_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    bcd_d   = bus.bcd_in;
                    acc_d   = 16'd0;
                    cnt_d   = 4'd0;
                    bad_d   = has_bad_digit(bus.bcd_in);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // {bcd, acc} >> 1: BCD LSB drops into accumulator bit 15.
                acc_d = {bcd_q[0], acc_q[15:1]};
                bcd_d = dabble_fix({1'b0, bcd_q[15:1]});
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (bad_q) begin
                        bin_out_d = 12'd0;
                        err_d     = 1'b1;
                    end else if (acc_d[15:12] != 4'd0) begin
                        bin_out_d = 12'hFFF;  // saturate above 4095
                        err_d     = 1'b1;
                    end else begin
                        bin_out_d = acc_d[11:0];
                        err_d     = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            bcd_q     <= 16'd0;
            acc_q     <= 16'd0;
            cnt_q     <= 4'd0;
            bad_q     <= 1'b0;
            bin_out_q <= 12'd0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            bad_q     <= bad_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.bin_out = bin_out_q;
    assign bus.err     = err_q;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: directed self-checking bench for bcd2bin. Inputs change and
// outputs are sampled 1ns after the rising edge.
module tb_bcd2bin;

    logic clk;
    logic RSTN;
    int   n_cmp;
    int   n_bad;

    bcd2bin_if bif ();

    bcd2bin dut (
        .clk  (clk),
        .RSTN (RSTN),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse en for one load edge, then wait (bounded) for ready.
    // lat = edges from load edge to ready (-1 on timeout); rdy_after = ready
    // one edge after the pulse. Returns 1ns after the DONE->IDLE edge.
    task automatic convert(input logic [15:0] bcd, output logic [11:0] b,
                           output logic e, output int lat, output logic rdy_after);
        bif.en     = 1'b1;
        bif.bcd_in = bcd;
        step();
        bif.en = 1'b0;
        lat = -1;
        b = 12'd0;
        e = 1'b0;
        rdy_after = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bif.ready) begin
                lat = i;
                b = bif.bin_out;
                e = bif.err;
                break;
            end
        end
        if (lat > 0) begin
            step();
            rdy_after = bif.ready;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    logic [11:0] b;
    logic        e;
    logic        ra;
    int          lat;
    int          hits;
    logic [15:0] bvec [6];
    logic [11:0] bexp [6];
    logic        eexp [6];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bif.en = 1'b0;
        bif.bcd_in = 16'h0;
        RSTN = 1'b0;
        step();
        step();
        chk("rst_bin", int'(bif.bin_out), 0);
        chk("rst_ready", int'(bif.ready), 0);
        chk("rst_err", int'(bif.err), 0);
        RSTN = 1'b1;
        step();

        // Back-to-back with en held high; bcd_in changes mid-conversion.
        bif.en = 1'b1;
        bif.bcd_in = 16'h3215;
        step();                      // load edge k
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) bif.bcd_in = 16'h1123;
            step();
            if (bif.ready) begin lat = i; break; end
        end
        chk("b2b_lat1", lat, 16);
        chk("b2b_bin1", int'(bif.bin_out), 'hC8F);
        chk("b2b_err1", int'(bif.err), 0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) chk("b2b_pulse1", int'(bif.ready), 0);
            if (bif.ready) begin lat = i; break; end
        end
        bif.en = 1'b0;
        chk("b2b_lat2", lat, 18);
        chk("b2b_bin2", int'(bif.bin_out), 'h463);
        chk("b2b_err2", int'(bif.err), 0);
        step();
        chk("b2b_pulse2", int'(bif.ready), 0);
        step();
        step();
        chk("hold_bin", int'(bif.bin_out), 'h463);

        // Boundaries and invalid digits.
        bvec[0] = 16'h0000; bexp[0] = 12'h000; eexp[0] = 1'b0;
        bvec[1] = 16'h4095; bexp[1] = 12'hFFF; eexp[1] = 1'b0;
        bvec[2] = 16'h4096; bexp[2] = 12'hFFF; eexp[2] = 1'b1;
        bvec[3] = 16'h9999; bexp[3] = 12'hFFF; eexp[3] = 1'b1;
        bvec[4] = 16'h12A4; bexp[4] = 12'h000; eexp[4] = 1'b1;
        bvec[5] = 16'hF999; bexp[5] = 12'h000; eexp[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            convert(bvec[i], b, e, lat, ra);
            chk($sformatf("bnd_lat_%h", bvec[i]), lat, 16);
            chk($sformatf("bnd_bin_%h", bvec[i]), int'(b), int'(bexp[i]));
            chk($sformatf("bnd_err_%h", bvec[i]), int'(e), int'(eexp[i]));
            chk($sformatf("bnd_pulse_%h", bvec[i]), int'(ra), 0);
        end

        // Leave nonzero outputs, then reset at step 8 of a conversion.
        convert(16'h9999, b, e, lat, ra);
        bif.en = 1'b1;
        bif.bcd_in = 16'h1234;
        step();                      // load edge k
        bif.en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        RSTN = 1'b0;
        step();
        chk("midrst_bin", int'(bif.bin_out), 0);
        chk("midrst_ready", int'(bif.ready), 0);
        chk("midrst_err", int'(bif.err), 0);
        RSTN = 1'b1;
        hits = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (bif.ready) hits++;
        end
        chk("midrst_no_ready", hits, 0);
        convert(16'h0042, b, e, lat, ra);
        chk("post_rst_lat", lat, 16);
        chk("post_rst_bin", int'(b), 'h02A);
        chk("post_rst_err", int'(e), 0);

        // Round trip over every 12-bit value.
        for (int v = 0; v < 4096; v++) begin
            convert(to_bcd(v), b, e, lat, ra);
            chk($sformatf("rt_%0d", v), int'({e, b}), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
